// File: rtl/row_sync_pkg.sv
// Shared types and default sizing for the row sync arbiter.
package row_sync_pkg;

    localparam int DefNumCores      = 4;
    localparam int DefTimeoutCycles = 1024;

    typedef enum logic [1:0] {
        StArb,
        StHold,
        StDrain,
        StEmptied
    } row_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first live requester at or after ptr_i, wrapping.
module rr_picker #(
    parameter int NumCores = 4,
    parameter int PtrW     = 2
) (
    input  logic [NumCores-1:0] req_i,
    input  logic [PtrW-1:0]     ptr_i,
    output logic [NumCores-1:0] grant_o,
    output logic                valid_o
);

    int              sum;
    logic [PtrW-1:0] idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int i = 0; i < NumCores; i++) begin
            sum = int'(ptr_i) + i;
            if (sum >= NumCores) begin
                sum = sum - NumCores;
            end
            idx = PtrW'(sum);
            if (!valid_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/row_sync_arbiter.sv
// Row-level URAM arbiter and "URAM emptied" barrier controller; all outputs registered.
// Define ROW_SYNC_TIMEOUT_EN to revoke grants held longer than TIMEOUT_CYCLES.
module row_sync_arbiter
    import row_sync_pkg::*;
#(
    parameter int NUM_CORES      = DefNumCores,
    parameter int TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] i_core_req,
    input  logic [NUM_CORES-1:0] i_core_locked,
    output logic [NUM_CORES-1:0] o_core_grant,
    output logic                 o_uram_emptied,
    output logic                 o_drain_start,
    input  logic                 i_drain_done,
    output logic                 o_timeout_err
);

    localparam int PtrW = $clog2(NUM_CORES);

    row_state_e           state_q;
    logic [NUM_CORES-1:0] grant_q;
    logic                 emptied_q;
    logic                 drain_start_q;
    logic [PtrW-1:0]      ptr_q;

    logic [NUM_CORES-1:0] pick_grant;
    logic                 pick_valid;
    logic [PtrW-1:0]      win_idx;
    logic [PtrW-1:0]      next_ptr;
    logic                 all_locked;
    logic                 none_locked;
    logic                 holder_req;

    rr_picker #(
        .NumCores (NUM_CORES),
        .PtrW     (PtrW)
    ) u_rr_picker (
        .req_i   (i_core_req),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .valid_o (pick_valid)
    );

    assign all_locked  = &i_core_locked;
    assign none_locked = ~|i_core_locked;
    assign holder_req  = |(i_core_req & grant_q);

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_grant[i]) begin
                win_idx = PtrW'(i);
            end
        end
        next_ptr = (win_idx == PtrW'(NUM_CORES - 1)) ? '0 : win_idx + 1'b1;
    end

`ifdef ROW_SYNC_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] hold_cnt_q;
    logic            timeout_err_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StArb;
            grant_q       <= '0;
            emptied_q     <= 1'b0;
            drain_start_q <= 1'b0;
            ptr_q         <= '0;
`ifdef ROW_SYNC_TIMEOUT_EN
            hold_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            drain_start_q <= 1'b0;
            unique case (state_q)
                StArb: begin
                    // Barrier wins over any pending request.
                    if (all_locked) begin
                        state_q       <= StDrain;
                        drain_start_q <= 1'b1;
                    end else if (pick_valid) begin
                        state_q <= StHold;
                        grant_q <= pick_grant;
                        ptr_q   <= next_ptr;
`ifdef ROW_SYNC_TIMEOUT_EN
                        hold_cnt_q <= '0;
`endif
                    end
                end
                StHold: begin
                    if (!holder_req) begin
                        state_q <= StArb;
                        grant_q <= '0;
`ifdef ROW_SYNC_TIMEOUT_EN
                    end else if (hold_cnt_q == CntW'(TIMEOUT_CYCLES)) begin
                        state_q       <= StArb;
                        grant_q       <= '0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
`endif
                    end
                end
                StDrain: begin
                    if (i_drain_done) begin
                        state_q   <= StEmptied;
                        emptied_q <= 1'b1;
                    end
                end
                StEmptied: begin
                    if (none_locked) begin
                        state_q   <= StArb;
                        emptied_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_core_grant   = grant_q;
    assign o_uram_emptied = emptied_q;
    assign o_drain_start  = drain_start_q;

`ifdef ROW_SYNC_TIMEOUT_EN
    assign o_timeout_err = timeout_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign o_timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_row_sync_arbiter.sv
// Self-checking bench for row_sync_arbiter: round-robin grants, barrier, reset and hold timeout.
module tb_row_sync_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] locked;
    logic [N-1:0] grant;
    logic         emptied;
    logic         drain_start;
    logic         done;
    logic         terr;

    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] exp_q[$];

    always #5 clk = ~clk;

    row_sync_arbiter #(
        .NUM_CORES      (N),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_core_req     (req),
        .i_core_locked  (locked),
        .o_core_grant   (grant),
        .o_uram_emptied (emptied),
        .o_drain_start  (drain_start),
        .i_drain_done   (done),
        .o_timeout_err  (terr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 4'b1111; locked = 4'b0000; done = 1'b0;
        tick(); tick();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (emptied !== 1'b0) begin errors++; $display("FAIL reset_emptied: got %b want 0", emptied); end
        checks++; if (drain_start !== 1'b0) begin errors++; $display("FAIL reset_drain_start: got %b want 0", drain_start); end
        checks++; if (terr !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", terr); end
        reset = 1'b0;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", grant); end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] e;
        reset = 1'b1; req = 4'b1111; tick(); reset = 1'b0;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        tick();
        for (int k = 0; k < 5; k++) begin
            e = exp_q.pop_front();
            checks++; if (grant !== e) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, grant, e); end
            req = 4'b1111 & ~grant;
            tick();
            checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_gap%0d: got %b want 0000", k, grant); end
            req = 4'b1111;
            if (k < 4) tick();
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_barrier_in_hold;
        req = 4'b0100;
        tick();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL hold_core2_grant: got %b want 0100", grant); end
        locked = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (drain_start !== 1'b0) begin errors++; $display("FAIL hold_defer_drain%0d: got %b want 0", i, drain_start); end
            checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL hold_keep_grant%0d: got %b want 0100", i, grant); end
        end
        req = 4'b0000;
        tick();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL hold_release: got %b want 0000", grant); end
        checks++; if (drain_start !== 1'b0) begin errors++; $display("FAIL release_no_drain: got %b want 0", drain_start); end
        tick();
        checks++; if (drain_start !== 1'b1) begin errors++; $display("FAIL drain_start_pulse: got %b want 1", drain_start); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL drain_no_grant: got %b want 0000", grant); end
        req = 4'b1111;
        tick();
        checks++; if (drain_start !== 1'b0) begin errors++; $display("FAIL drain_start_width: got %b want 0", drain_start); end
    endtask

    task automatic test_drain_emptied;
        logic [N-1:0] e;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (emptied !== 1'b0) begin errors++; $display("FAIL drain_wait_emptied%0d: got %b want 0", i, emptied); end
            checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL drain_wait_grant%0d: got %b want 0000", i, grant); end
        end
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (emptied !== 1'b1) begin errors++; $display("FAIL emptied_set: got %b want 1", emptied); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (emptied !== 1'b1) begin errors++; $display("FAIL emptied_hold%0d: got %b want 1", i, emptied); end
            checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL emptied_no_grant%0d: got %b want 0000", i, grant); end
        end
        locked = 4'b0000;
        exp_q.push_back(4'b1000);
        tick();
        checks++; if (emptied !== 1'b0) begin errors++; $display("FAIL emptied_clear: got %b want 0", emptied); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL emptied_exit_grant: got %b want 0000", grant); end
        tick();
        if (exp_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL resume_grant: got %b want <none queued>", grant);
        end else begin
            e = exp_q.pop_front();
            checks++; if (grant !== e) begin errors++; $display("FAIL resume_grant: got %b want %b", grant, e); end
        end
    endtask

    task automatic test_emptied_one_cycle;
        req = 4'b0000; locked = 4'b1111;
        tick(); tick();
        checks++; if (drain_start !== 1'b1) begin errors++; $display("FAIL short_drain_start: got %b want 1", drain_start); end
        locked = 4'b0000; done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (emptied !== 1'b1) begin errors++; $display("FAIL short_emptied_high: got %b want 1", emptied); end
        tick();
        checks++; if (emptied !== 1'b0) begin errors++; $display("FAIL short_emptied_low: got %b want 0", emptied); end
    endtask

    task automatic test_reset_in_drain;
        req = 4'b0010;
        tick();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rst_pre_grant: got %b want 0010", grant); end
        req = 4'b0000; locked = 4'b1111;
        tick(); tick();
        checks++; if (drain_start !== 1'b1) begin errors++; $display("FAIL rst_pre_drain: got %b want 1", drain_start); end
        reset = 1'b1; done = 1'b1; req = 4'b1111;
        tick();
        checks++; if (emptied !== 1'b0) begin errors++; $display("FAIL rst_drain_emptied: got %b want 0", emptied); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_drain_grant: got %b want 0000", grant); end
        checks++; if (drain_start !== 1'b0) begin errors++; $display("FAIL rst_drain_start: got %b want 0", drain_start); end
        reset = 1'b0; done = 1'b0; locked = 4'b0000;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rst_pointer_zero: got %b want 0001", grant); end
    endtask

    task automatic test_hold_timeout;
        int held;
        reset = 1'b1; req = 4'b0010; locked = 4'b0000; done = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL to_first_grant: got %b want 0010", grant); end
        held = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (grant == 4'b0010) held++;
            else break;
        end
`ifdef ROW_SYNC_TIMEOUT_EN
        checks++; if (held !== 9) begin errors++; $display("FAIL to_hold_cycles: got %0d want 9", held); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL to_revoked: got %b want 0000", grant); end
        checks++; if (terr !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b want 1", terr); end
        tick();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL to_regrant: got %b want 0010", grant); end
        checks++; if (terr !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", terr); end
`else
        checks++; if (held !== 41) begin errors++; $display("FAIL hold_forever: got %0d want 41", held); end
        checks++; if (terr !== 1'b0) begin errors++; $display("FAIL timeout_err_tied: got %b want 0", terr); end
`endif
    endtask

    initial begin
        reset = 1'b1; req = '0; locked = '0; done = 1'b0;
        test_reset();
        test_round_robin();
        test_barrier_in_hold();
        test_drain_emptied();
        test_emptied_one_cycle();
        test_reset_in_drain();
        test_hold_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
